// File: rtl/alias_bus_checker.sv
// alias_bus_checker
//   Consumes NUM_SAMPLES samples of a three-way aliased bus (a/b/c) after
//   start. It checks that all three nets agree with each other and with
//   EXPECT, and accumulates a saturating mismatch count, the index of the
//   first bad sample and a rotate-XOR signature of a. It then reports
//   done/pass.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a run (honoured in IDLE or DONE only)
//   in_valid/in_ready sample handshake; in_ready high only while running
//   a, b, c           aliased bus nets
//   busy, done, pass  run status; pass = done && no mismatches
//   mismatch_cnt      bad samples, saturating at 255
//   first_bad_idx     index of first bad sample, 16'hffff if none
//   sample_cnt        samples accepted this run
//   signature         rotate-left-by-1 XOR accumulator of a
module alias_bus_checker #(
  parameter int                 WIDTH       = 32,
  parameter int                 NUM_SAMPLES = 16,
  parameter logic [WIDTH-1:0]   EXPECT      = 32'hdeadbeef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       mismatch_cnt,
  output logic [15:0]      first_bad_idx,
  output logic [15:0]      sample_cnt,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] LAST   = 16'(NUM_SAMPLES - 1);
  localparam logic [15:0] NO_BAD = 16'hffff;

  state_t state, state_nx;
  logic   accept, bad, launch;

  assign accept = in_valid && (state == RUN);
  assign bad    = !(a == b && b == c && a == EXPECT);
  // A new run can only be launched from a non-running state.
  assign launch = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && sample_cnt == LAST) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_cnt  <= '0;
      first_bad_idx <= NO_BAD;
      sample_cnt    <= '0;
      signature     <= '0;
    end else if (launch) begin
      mismatch_cnt  <= '0;
      first_bad_idx <= NO_BAD;
      sample_cnt    <= '0;
      signature     <= '0;
    end else if (accept) begin
      if (bad && mismatch_cnt != 8'hff) mismatch_cnt <= mismatch_cnt + 8'd1;
      // Indices only reach NUM_SAMPLES-1 <= 65534, so 16'hffff is a safe "none" marker.
      if (bad && first_bad_idx == NO_BAD) first_bad_idx <= sample_cnt;
      signature  <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ a;
      sample_cnt <= sample_cnt + 16'd1;
    end
  end

  // Status decodes from registered state only; nothing combinational from a/b/c/in_valid.
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign pass     = done && (mismatch_cnt == 8'd0);

endmodule

// File: tb/tb_alias_bus_checker.sv
module tb_alias_bus_checker;
  localparam logic [31:0] EXP0 = 32'hdeadbeef;
  localparam int          N0   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, start2, in_valid;
  logic [31:0] a, b, c;

  logic rdy0, busy0, done0, pass0, rdy1, busy1, done1, pass1, rdy2, busy2, done2, pass2;
  logic [7:0]  mc0, mc1, mc2;
  logic [15:0] fb0, fb1, fb2, sc0, sc1, sc2;
  logic [31:0] sig0, sig1, sig2;

  alias_bus_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .in_ready(rdy0), .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mc0),
    .first_bad_idx(fb0), .sample_cnt(sc0), .signature(sig0));

  alias_bus_checker #(.NUM_SAMPLES(2), .EXPECT(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .in_ready(rdy1), .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mc1),
    .first_bad_idx(fb1), .sample_cnt(sc1), .signature(sig1));

  alias_bus_checker #(.NUM_SAMPLES(300)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .in_ready(rdy2), .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(mc2),
    .first_bad_idx(fb2), .sample_cnt(sc2), .signature(sig2));

  int errs = 0;
  int checks = 0;

  // Reference model for u0: the run is just the list of accepted samples;
  // every result is a function of that list.
  bit          m_run, m_done;
  logic [31:0] qa[$];
  bit          qbad[$];

  function automatic logic [31:0] exp_sig();
    logic [31:0] s = '0;
    foreach (qa[i]) s = {s[30:0], s[31]} ^ qa[i];
    return s;
  endfunction

  function automatic logic [7:0] exp_mc();
    int n = 0;
    foreach (qbad[i]) if (qbad[i]) n++;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  function automatic logic [15:0] exp_fb();
    foreach (qbad[i]) if (qbad[i]) return 16'(i);
    return 16'hffff;
  endfunction

  // Drive one cycle for u0, advance the model across the edge, settle 1 ns after it.
  task automatic drive(input bit s, input bit v, input logic [31:0] ia, ib, ic);
    start0 = s; in_valid = v; a = ia; b = ib; c = ic;
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_done = 0; qa.delete(); qbad.delete();
    end else if (m_run) begin
      if (v) begin
        qa.push_back(ia);
        qbad.push_back(!(ia == ib && ib == ic && ia == EXP0));
        if (qa.size() == N0) begin m_run = 0; m_done = 1; end
      end
    end else if (s) begin
      m_run = 1; m_done = 0; qa.delete(); qbad.delete();
    end
    #1;
  endtask

  // Random sample: good, or corrupted on one net, or consistent but wrong value.
  task automatic rand_sample(output logic [31:0] ra, rb, rc);
    ra = EXP0; rb = EXP0; rc = EXP0;
    case ($urandom_range(0, 3))
      1: ra = $urandom;
      2: rb = EXP0 ^ (32'h1 << $urandom_range(0, 31));
      3: begin ra = $urandom | 32'h1; if (ra == EXP0) ra = ~EXP0; rb = ra; rc = ra; end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 1, EXP0, EXP0, EXP0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1;
    checks++; if (rdy0 !== 1'b0)       begin errs++; $display("FAIL reset_rdy got=%0b exp=0", rdy0); end
    checks++; if (busy0 !== 1'b0)      begin errs++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
    checks++; if (done0 !== 1'b0)      begin errs++; $display("FAIL reset_done got=%0b exp=0", done0); end
    checks++; if (pass0 !== 1'b0)      begin errs++; $display("FAIL reset_pass got=%0b exp=0", pass0); end
    checks++; if (mc0 !== 8'd0)        begin errs++; $display("FAIL reset_mc got=%0d exp=0", mc0); end
    checks++; if (fb0 !== 16'hffff)    begin errs++; $display("FAIL reset_fb got=%h exp=ffff", fb0); end
    checks++; if (sc0 !== 16'd0)       begin errs++; $display("FAIL reset_sc got=%0d exp=0", sc0); end
    checks++; if (sig0 !== 32'd0)      begin errs++; $display("FAIL reset_sig got=%h exp=0", sig0); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errs++; $display("FAIL reset_busy12 got=%0b%0b exp=00", busy1, busy2); end
  endtask

  task automatic test_nominal();
    int edges, done_edge;
    done_edge = -1;
    drive(1, 0, $urandom, $urandom, $urandom);
    edges = 1;
    checks++; if (busy0 !== 1'b1 || rdy0 !== 1'b1) begin errs++; $display("FAIL nom_busy got=%0b/%0b exp=1/1", busy0, rdy0); end
    for (int i = 0; i < 20 && done_edge < 0; i++) begin
      drive(0, 1, EXP0, EXP0, EXP0);
      edges++;
      checks++; if (done0 !== m_done) begin errs++; $display("FAIL nom_done_cyc%0d got=%0b exp=%0b", i, done0, m_done); end
      checks++; if (sc0 !== 16'(qa.size())) begin errs++; $display("FAIL nom_sc_cyc%0d got=%0d exp=%0d", i, sc0, qa.size()); end
      if (done0 === 1'b1) done_edge = edges;
    end
    checks++; if (done_edge != 17) begin errs++; $display("FAIL nom_latency got=%0d exp=17", done_edge); end
    checks++; if (pass0 !== 1'b1)     begin errs++; $display("FAIL nom_pass got=%0b exp=1", pass0); end
    checks++; if (mc0 !== 8'd0)       begin errs++; $display("FAIL nom_mc got=%0d exp=0", mc0); end
    checks++; if (fb0 !== 16'hffff)   begin errs++; $display("FAIL nom_fb got=%h exp=ffff", fb0); end
    checks++; if (sc0 !== 16'd16)     begin errs++; $display("FAIL nom_sc got=%0d exp=16", sc0); end
    checks++; if (sig0 !== exp_sig()) begin errs++; $display("FAIL nom_sig got=%h exp=%h", sig0, exp_sig()); end
    checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin errs++; $display("FAIL nom_idle got=%0b/%0b exp=0/0", busy0, rdy0); end
  endtask

  task automatic test_single_fault();
    drive(1, 0, 0, 0, 0);
    checks++; if (sc0 !== 16'd0 || done0 !== 1'b0) begin errs++; $display("FAIL sf_restart got sc=%0d done=%0b exp 0/0", sc0, done0); end
    for (int i = 0; i < 16; i++) drive(0, 1, EXP0, EXP0, (i == 5) ? 32'h0 : EXP0);
    checks++; if (done0 !== 1'b1)     begin errs++; $display("FAIL sf_done got=%0b exp=1", done0); end
    checks++; if (mc0 !== 8'd1)       begin errs++; $display("FAIL sf_mc got=%0d exp=1", mc0); end
    checks++; if (fb0 !== 16'd5)      begin errs++; $display("FAIL sf_fb got=%0d exp=5", fb0); end
    checks++; if (pass0 !== 1'b0)     begin errs++; $display("FAIL sf_pass got=%0b exp=0", pass0); end
    checks++; if (sig0 !== exp_sig()) begin errs++; $display("FAIL sf_sig got=%h exp=%h", sig0, exp_sig()); end
  endtask

  task automatic test_handshake_gaps();
    logic [31:0] ra, rb, rc;
    int i;
    drive(1, 0, 0, 0, 0);
    i = 0;
    while (i < 100 && !m_done) begin
      rand_sample(ra, rb, rc);
      drive(i == 9, (i % 4 == 0) || (i % 4 == 3), ra, rb, rc);
      checks++; if (done0 !== m_done)           begin errs++; $display("FAIL hs_done_cyc%0d got=%0b exp=%0b", i, done0, m_done); end
      checks++; if (sc0 !== 16'(qa.size()))      begin errs++; $display("FAIL hs_sc_cyc%0d got=%0d exp=%0d", i, sc0, qa.size()); end
      checks++; if (mc0 !== exp_mc())            begin errs++; $display("FAIL hs_mc_cyc%0d got=%0d exp=%0d", i, mc0, exp_mc()); end
      checks++; if (fb0 !== exp_fb())            begin errs++; $display("FAIL hs_fb_cyc%0d got=%h exp=%h", i, fb0, exp_fb()); end
      checks++; if (sig0 !== exp_sig())          begin errs++; $display("FAIL hs_sig_cyc%0d got=%h exp=%h", i, sig0, exp_sig()); end
      checks++; if (pass0 !== (m_done && exp_mc() == 0)) begin errs++; $display("FAIL hs_pass_cyc%0d got=%0b", i, pass0); end
      i++;
    end
    checks++; if (done0 !== 1'b1 || sc0 !== 16'd16) begin errs++; $display("FAIL hs_timeout got done=%0b sc=%0d exp 1/16", done0, sc0); end
    // Restart from DONE clears everything on the same edge.
    drive(1, 1, $urandom, $urandom, $urandom);
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin errs++; $display("FAIL hs_restart_state got done=%0b busy=%0b exp 0/1", done0, busy0); end
    checks++; if (sc0 !== 16'd0 || mc0 !== 8'd0)    begin errs++; $display("FAIL hs_restart_cnt got sc=%0d mc=%0d exp 0/0", sc0, mc0); end
    checks++; if (fb0 !== 16'hffff || sig0 !== 32'd0) begin errs++; $display("FAIL hs_restart_res got fb=%h sig=%h exp ffff/0", fb0, sig0); end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 7; i++) drive(0, 1, $urandom, $urandom, $urandom);
    checks++; if (sc0 !== 16'd7) begin errs++; $display("FAIL rm_pre got=%0d exp=7", sc0); end
    rst_n = 0;
    drive(1, 1, EXP0, EXP0, EXP0);
    rst_n = 1;
    checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0)
      begin errs++; $display("FAIL rm_status got b=%0b r=%0b d=%0b p=%0b exp 0000", busy0, rdy0, done0, pass0); end
    checks++; if (sc0 !== 16'd0 || mc0 !== 8'd0 || fb0 !== 16'hffff || sig0 !== 32'd0)
      begin errs++; $display("FAIL rm_results got sc=%0d mc=%0d fb=%h sig=%h exp 0/0/ffff/0", sc0, mc0, fb0, sig0); end
    for (int i = 0; i < 3; i++) drive(0, 1, $urandom, $urandom, $urandom);
    checks++; if (sc0 !== 16'd0 || busy0 !== 1'b0) begin errs++; $display("FAIL rm_noaccept got sc=%0d busy=%0b exp 0/0", sc0, busy0); end
  endtask

  task automatic test_sig_wrap();
    start1 = 1;
    drive(0, 0, 0, 0, 0);
    start1 = 0;
    checks++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL sw_rdy got=%0b exp=1", rdy1); end
    drive(0, 1, 32'h80000000, 32'h80000000, 32'h80000000);
    checks++; if (sig1 !== 32'h80000000) begin errs++; $display("FAIL sw_sig1 got=%h exp=80000000", sig1); end
    checks++; if (mc1 !== 8'd1 || fb1 !== 16'd0) begin errs++; $display("FAIL sw_bad1 got mc=%0d fb=%0d exp 1/0", mc1, fb1); end
    drive(0, 1, 32'h0, 32'h0, 32'h0);
    checks++; if (sig1 !== 32'h00000001) begin errs++; $display("FAIL sw_sig2 got=%h exp=00000001", sig1); end
    checks++; if (done1 !== 1'b1 || pass1 !== 1'b0 || mc1 !== 8'd1 || fb1 !== 16'd0 || sc1 !== 16'd2)
      begin errs++; $display("FAIL sw_final got d=%0b p=%0b mc=%0d fb=%0d sc=%0d exp 1/0/1/0/2", done1, pass1, mc1, fb1, sc1); end
  endtask

  task automatic test_saturation();
    logic [31:0] s;
    s = '0;
    start2 = 1;
    drive(0, 0, 0, 0, 0);
    start2 = 0;
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 32'h1, 32'h2, $urandom);
      s = {s[30:0], s[31]} ^ 32'h1;
      if (i == 255) begin
        checks++; if (mc2 !== 8'd255) begin errs++; $display("FAIL sat_256 got=%0d exp=255", mc2); end
      end
    end
    checks++; if (mc2 !== 8'd255)   begin errs++; $display("FAIL sat_mc got=%0d exp=255", mc2); end
    checks++; if (fb2 !== 16'd0)    begin errs++; $display("FAIL sat_fb got=%0d exp=0", fb2); end
    checks++; if (sc2 !== 16'd300)  begin errs++; $display("FAIL sat_sc got=%0d exp=300", sc2); end
    checks++; if (done2 !== 1'b1 || pass2 !== 1'b0) begin errs++; $display("FAIL sat_done got d=%0b p=%0b exp 1/0", done2, pass2); end
    checks++; if (sig2 !== s)       begin errs++; $display("FAIL sat_sig got=%h exp=%h", sig2, s); end
  endtask

  initial begin
    rst_n = 0; start0 = 0; start1 = 0; start2 = 0; in_valid = 0; a = 0; b = 0; c = 0;
    test_reset();
    test_nominal();
    test_single_fault();
    test_handshake_gaps();
    test_reset_mid_run();
    test_sig_wrap();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alias_bus_checker.md
# alias_bus_checker

Sequential consumer for the three-way aliased 32-bit bus that a transfer stage produces on its `a`/`b`/`c` nets. After `start`, it accepts a fixed number of samples over a valid/ready handshake. For each sample it checks that all three nets agree with each other and with an expected constant. It accumulates a mismatch count, the index of the first bad sample and a rotate-XOR signature, then reports pass/fail. It sits directly downstream of the aliasing stage in self-checking test harnesses.

## Interface
- `WIDTH`, 32, bus width.
- `NUM_SAMPLES`, 16, samples per run; legal range 1..65535.
- `EXPECT`, 32'hdeadbeef, value every net must carry (WIDTH bits).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin run; honoured only in IDLE or DONE.
- `in_valid`  in  1  sample present on `a`/`b`/`c`.
- `a`, `b`, `c`  in  WIDTH  aliased bus nets, read only.
- `in_ready`  out  1  high only in RUN.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE, held until next `start` or reset.
- `pass`  out  1  `done && mismatch_cnt == 0`.
- `mismatch_cnt`  out  8  mismatching samples, saturates at 255.
- `first_bad_idx`  out  16  index of first mismatching sample; 16'hffff if none.
- `sample_cnt`  out  16  samples accepted this run.
- `signature`  out  WIDTH  rotate-XOR accumulator.

## Operation
- States: IDLE, RUN, DONE (2-bit encoded).
- IDLE -> RUN on `start`.
- DONE -> RUN on `start`.
- RUN ignores `start`.
- On entry to RUN, on the same edge: `sample_cnt`=0, `mismatch_cnt`=0, `first_bad_idx`=16'hffff, `signature`=0.
- Accept: `in_valid && in_ready`. Cycles without accept change nothing.
- Per accepted sample:
  - `bad` = !(a==b && b==c && a==EXPECT).
  - If `bad`: `mismatch_cnt` = min(`mismatch_cnt`+1, 255).
  - If `bad` and `first_bad_idx`==16'hffff: `first_bad_idx` = current `sample_cnt`.
  - `signature` = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ a. Only `a` feeds the signature.
  - `sample_cnt` += 1.
- RUN -> DONE on the edge that accepts sample number NUM_SAMPLES, i.e. when `sample_cnt`==NUM_SAMPLES-1 before the increment.
- In DONE, results are frozen and `in_ready`=0.
- Outputs are registered or decoded from registered state only. There is no combinational path from `a`/`b`/`c`/`in_valid` to any output.

## Timing
- Reset (`rst_n`=0 at an edge) gives, after that edge:
  - state IDLE;
  - `in_ready`=0, `busy`=0, `done`=0, `pass`=0;
  - `mismatch_cnt`=0, `first_bad_idx`=16'hffff, `sample_cnt`=0, `signature`=0.
- Reset overrides `start` and accepts in the same cycle.
- Reset mid-RUN aborts the run with no partial results retained.
- `start` sampled at edge N: `busy`=`in_ready`=1 from cycle N+1. The first accept is possible at edge N+1.
- Accumulator update latency: 1 cycle after the accepting edge.
- Final accept at edge M: `done`=`pass`-valid, `busy`=0 and `in_ready`=0 from cycle M+1.
- Minimum run length: NUM_SAMPLES+1 edges from `start` to DONE, with `in_valid` held high.
- `start` in DONE on the same cycle that the bench reads results is legal. Results clear on that edge.

## Test plan
- Nominal run:
  - Stimulus: defaults; a=b=c=32'hdeadbeef; `in_valid` held high 16 cycles after `start`.
  - Required: `done`=1 exactly 17 edges after `start`; `pass`=1, `mismatch_cnt`=0, `first_bad_idx`=16'hffff, `sample_cnt`=16.
- Single fault:
  - Stimulus: as nominal, but sample 5 has c=0.
  - Required: `mismatch_cnt`=1, `first_bad_idx`=5, `pass`=0.
- Signature wrap:
  - Stimulus: NUM_SAMPLES=2, EXPECT=0; samples a=b=c=32'h80000000, then 0.
  - Required: `signature`=32'h80000000 after the first accept, then 32'h00000001; `mismatch_cnt`=1, `first_bad_idx`=0.
- Saturation:
  - Stimulus: NUM_SAMPLES=300; every sample has a=1, b=2.
  - Required: `mismatch_cnt`=255 (no wrap), `first_bad_idx`=0, `sample_cnt`=300.
- Handshake gaps:
  - Stimulus: `in_valid` toggled 1,0,0,1 repeatedly, with `start` pulsed mid-RUN.
  - Required: only valid cycles counted; `start` ignored; `done` arrives after exactly 16 accepts.
  - Stimulus: `start` pulsed again in DONE.
  - Required: all results clear on that edge.
- Reset mid-run:
  - Stimulus: `rst_n`=0 for one cycle after 7 accepts.
  - Required: all outputs at reset values next cycle; state IDLE; no accept until a new `start`.
